// File: rtl/eth_pkg.sv
// Shared Ethernet RX/TX definitions: CRC-32 constants,
// preamble/SFD dibits and the receive state encoding.
package eth_pkg;

  localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hC704DD7B;

  localparam logic [1:0] PREAMBLE_DIBIT = 2'b01;
  localparam logic [1:0] SFD_DIBIT      = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    PREAMBLE,
    DATA,
    DROP
  } rx_state_e;

  function automatic logic [31:0] crc32_bit(
    input logic [31:0] c,
    input logic        b
  );
    logic fb;
    fb = c[31] ^ b;
    return {c[30:0], 1'b0} ^ (fb ? CRC32_POLY : 32'h0);
  endfunction

endpackage

// File: rtl/eth_crc32_dibit.sv
// Combinational CRC-32 advance by one RMII dibit,
// rxd[0] applied first; shared between RX and TX.
module eth_crc32_dibit
  import eth_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [1:0]  dibit,
  output logic [31:0] crc_out
);

  logic [31:0] mid;

  always_comb begin
    mid     = crc32_bit(crc_in, dibit[0]);
    crc_out = crc32_bit(mid, dibit[1]);
  end

endmodule

// File: rtl/eth_rx_fcs.sv
// RMII receive front end: preamble/SFD hunt, byte assembly,
// running CRC-32 and end-of-frame status reporting.
module eth_rx_fcs
  import eth_pkg::*;
#(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1522,
  parameter int CNT_W   = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx_dv,
  input  logic [1:0]       rxd,
  output logic             frame_start,
  output logic [7:0]       data_byte,
  output logic             data_valid,
  output logic             frame_done,
  output logic             fcs_ok,
  output logic             err_align,
  output logic             err_len,
  output logic [CNT_W-1:0] byte_count
);

  localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_LEN);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  rx_state_e        state_q, state_d;
  logic [31:0]      crc_q, crc_nxt;
  logic [1:0]       phase_q;
  logic [5:0]       shift_q;
  logic [CNT_W-1:0] cnt_q, cnt_inc;

  logic      sfd_hit, take, fin;
  rx_state_e pre_next;
  logic      pre_sfd;

  eth_crc32_dibit u_crc (
    .crc_in  (crc_q),
    .dibit   (rxd),
    .crc_out (crc_nxt)
  );

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + ONE_C;

  // Preamble rules, also applied to the first dibit seen from IDLE
  always_comb begin
    pre_next = PREAMBLE;
    pre_sfd  = 1'b0;
    unique case (1'b1)
      (rxd == SFD_DIBIT): begin
        pre_next = DATA;
        pre_sfd  = 1'b1;
      end
      (rxd == 2'b10): pre_next = DROP;
      default:        pre_next = PREAMBLE;
    endcase
  end

  always_comb begin
    state_d = state_q;
    sfd_hit = 1'b0;
    take    = 1'b0;
    fin     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rx_dv) begin
          state_d = pre_next;
          sfd_hit = pre_sfd;
        end
      end
      PREAMBLE: begin
        if (!rx_dv) begin
          state_d = IDLE;
        end else begin
          state_d = pre_next;
          sfd_hit = pre_sfd;
        end
      end
      DATA: begin
        if (rx_dv) begin
          take = 1'b1;
        end else begin
          fin     = 1'b1;
          state_d = IDLE;
        end
      end
      DROP: begin
        if (!rx_dv) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      crc_q       <= CRC32_INIT;
      phase_q     <= 2'd0;
      shift_q     <= 6'd0;
      cnt_q       <= '0;
      frame_start <= 1'b0;
      data_byte   <= 8'd0;
      data_valid  <= 1'b0;
      frame_done  <= 1'b0;
      fcs_ok      <= 1'b0;
      err_align   <= 1'b0;
      err_len     <= 1'b0;
      byte_count  <= '0;
    end else begin
      state_q     <= state_d;
      frame_start <= sfd_hit;
      frame_done  <= fin;
      data_valid  <= 1'b0;
      if (sfd_hit) begin
        crc_q      <= CRC32_INIT;
        phase_q    <= 2'd0;
        cnt_q      <= '0;
        fcs_ok     <= 1'b0;
        err_align  <= 1'b0;
        err_len    <= 1'b0;
        byte_count <= '0;
      end
      if (take) begin
        crc_q   <= crc_nxt;
        phase_q <= phase_q + 2'd1;
        shift_q <= {rxd, shift_q[5:2]};
        if (phase_q == 2'd3) begin
          data_byte  <= {rxd, shift_q};
          data_valid <= 1'b1;
          cnt_q      <= cnt_inc;
        end
      end
      // Residue includes the received FCS; any leftover dibits spoil it
      if (fin) begin
        fcs_ok     <= (crc_q == CRC32_RESIDUE) && (phase_q == 2'd0);
        err_align  <= (phase_q != 2'd0);
        err_len    <= (cnt_q < MIN_C) || (cnt_q > MAX_C);
        byte_count <= cnt_q;
      end
    end
  end

endmodule

// File: tb/tb_eth_rx_fcs.sv
// Table-driven and randomized frame checks for eth_rx_fcs
// against a byte-level CRC-32 reference model.
module tb_eth_rx_fcs;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_dv;
  logic [1:0]  rxd;
  logic        frame_start;
  logic [7:0]  data_byte;
  logic        data_valid;
  logic        frame_done;
  logic        fcs_ok;
  logic        err_align;
  logic        err_len;
  logic [10:0] byte_count;

  always #10 clk = ~clk;

  eth_rx_fcs dut (
    .clk         (clk),
    .reset       (reset),
    .rx_dv       (rx_dv),
    .rxd         (rxd),
    .frame_start (frame_start),
    .data_byte   (data_byte),
    .data_valid  (data_valid),
    .frame_done  (frame_done),
    .fcs_ok      (fcs_ok),
    .err_align   (err_align),
    .err_len     (err_len),
    .byte_count  (byte_count)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  int         n_start, n_dv, n_done;
  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];
  logic       d_fcs, d_len, d_align;
  int         d_cnt;
  bit         overlap = 1'b0;

  always @(negedge clk) begin
    if (frame_start) n_start++;
    if (data_valid) begin
      n_dv++;
      rx_q.push_back(data_byte);
    end
    if (frame_done) begin
      n_done++;
      d_fcs   = fcs_ok;
      d_len   = err_len;
      d_align = err_align;
      d_cnt   = int'(byte_count);
    end
    if (data_valid && frame_done) overlap = 1'b1;
  end

  task automatic clear_mon();
    n_start = 0;
    n_dv    = 0;
    n_done  = 0;
    rx_q.delete();
    d_fcs   = 1'b0;
    d_len   = 1'b0;
    d_align = 1'b0;
    d_cnt   = -1;
  endtask

  task automatic dib(input logic dv, input logic [1:0] d);
    @(posedge clk);
    #1;
    rx_dv = dv;
    rxd   = d;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int k = 0; k < 4; k++) dib(1'b1, b[2*k +: 2]);
  endtask

  task automatic gap(input int n);
    for (int k = 0; k < n; k++) dib(1'b0, 2'b00);
  endtask

  task automatic send_pre();
    for (int k = 0; k < 7; k++) send_byte(8'h55);
    send_byte(8'hD5);
  endtask

  task automatic send_body(input int extra);
    foreach (tx_q[i]) send_byte(tx_q[i]);
    for (int k = 0; k < extra; k++) dib(1'b1, 2'($urandom));
    gap(6);
  endtask

  // Standard reflected Ethernet CRC-32 over the first n bytes of tx_q
  function automatic logic [31:0] crc_first(input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h0, tx_q[i]};
      for (int j = 0; j < 8; j++)
        c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic bit model_ok();
    int n;
    logic [31:0] c;
    n = tx_q.size();
    if (n < 4) return 1'b0;
    c = crc_first(n - 4);
    return c == {tx_q[n-1], tx_q[n-2], tx_q[n-3], tx_q[n-4]};
  endfunction

  task automatic build(input int plen, input int flip_byte, input int flip_bit);
    logic [31:0] c;
    logic [7:0]  t;
    tx_q.delete();
    for (int i = 0; i < plen; i++) tx_q.push_back(8'($urandom));
    c = crc_first(plen);
    for (int i = 0; i < 4; i++) tx_q.push_back(c[8*i +: 8]);
    if (flip_byte >= 0) begin
      t = tx_q[flip_byte];
      t[flip_bit] = ~t[flip_bit];
      tx_q[flip_byte] = t;
    end
  endtask

  task automatic check_frame(input string tag, input bit efcs, input bit elen,
                             input bit ealign, input int ecnt);
    int bad;
    chk({tag, ".starts"}, n_start, 1);
    chk({tag, ".dv"}, n_dv, tx_q.size());
    chk({tag, ".done"}, n_done, 1);
    chk({tag, ".fcs_ok"}, d_fcs, efcs);
    chk({tag, ".err_len"}, d_len, elen);
    chk({tag, ".err_align"}, d_align, ealign);
    chk({tag, ".count"}, d_cnt, ecnt);
    chk({tag, ".hold_fcs"}, fcs_ok, efcs);
    bad = 0;
    if (rx_q.size() != tx_q.size()) bad = 1;
    else foreach (tx_q[i]) if (rx_q[i] !== tx_q[i]) bad++;
    chk({tag, ".bytes_bad"}, bad, 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".pulses"}, {frame_start, data_valid, frame_done}, 0);
    chk({tag, ".status"}, {fcs_ok, err_align, err_len}, 0);
    chk({tag, ".data_byte"}, data_byte, 0);
    chk({tag, ".byte_count"}, byte_count, 0);
  endtask

  typedef struct {
    int plen;
    int flip;
    int extra;
    bit efcs;
    bit elen;
    bit ealign;
    int ecnt;
  } vec_t;

  vec_t vt[9];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit efcs, elen, ealign;
    int plen, fb, fbit, extra, tot;
    logic [7:0] s123[13];

    vt[0] = '{60,   -1, 0, 1'b1, 1'b0, 1'b0, 64};
    vt[1] = '{60,   10, 0, 1'b0, 1'b0, 1'b0, 64};
    vt[2] = '{60,   -1, 1, 1'b0, 1'b0, 1'b1, 64};
    vt[3] = '{60,   -1, 3, 1'b0, 1'b0, 1'b1, 64};
    vt[4] = '{59,   -1, 0, 1'b1, 1'b1, 1'b0, 63};
    vt[5] = '{0,    -1, 0, 1'b1, 1'b1, 1'b0, 4};
    vt[6] = '{1518, -1, 0, 1'b1, 1'b0, 1'b0, 1522};
    vt[7] = '{1519, -1, 0, 1'b1, 1'b1, 1'b0, 1523};
    vt[8] = '{2100, -1, 0, 1'b1, 1'b1, 1'b0, 2047};

    reset = 1'b1;
    rx_dv = 1'b0;
    rxd   = 2'b00;
    clear_mon();
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    reset = 1'b0;
    gap(3);
    chk_zero("post_reset");

    for (int v = 0; v < 9; v++) begin
      clear_mon();
      build(vt[v].plen, vt[v].flip, 0);
      send_pre();
      send_body(vt[v].extra);
      check_frame($sformatf("vec%0d", v), vt[v].efcs, vt[v].elen,
                  vt[v].ealign, vt[v].ecnt);
    end

    s123 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38,
             8'h39, 8'h26, 8'h39, 8'hF4, 8'hCB};
    clear_mon();
    tx_q.delete();
    foreach (s123[i]) tx_q.push_back(s123[i]);
    send_pre();
    send_body(0);
    check_frame("ascii", 1'b1, 1'b1, 1'b0, 13);

    clear_mon();
    for (int k = 0; k < 3; k++) send_byte(8'h55);
    dib(1'b1, 2'b10);
    for (int k = 0; k < 4; k++) send_byte(8'h55);
    send_byte(8'hD5);
    for (int k = 0; k < 20; k++) send_byte(8'($urandom));
    gap(6);
    chk("badpre.starts", n_start, 0);
    chk("badpre.dv", n_dv, 0);
    chk("badpre.done", n_done, 0);
    clear_mon();
    build(60, -1, 0);
    send_pre();
    send_body(0);
    check_frame("after_badpre", 1'b1, 1'b0, 1'b0, 64);

    clear_mon();
    build(60, -1, 0);
    send_pre();
    for (int i = 0; i < 20; i++) send_byte(tx_q[i]);
    @(posedge clk);
    #3;
    reset = 1'b1;
    rx_dv = 1'b0;
    #1;
    chk_zero("midreset");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    gap(6);
    chk("midreset.done", n_done, 0);
    clear_mon();
    build(60, -1, 0);
    send_pre();
    send_body(0);
    check_frame("after_reset", 1'b1, 1'b0, 1'b0, 64);

    for (int r = 0; r < 16; r++) begin
      plen  = int'($urandom_range(0, 80));
      fb    = -1;
      fbit  = 0;
      extra = 0;
      if ($urandom_range(0, 2) == 0) begin
        fb   = int'($urandom_range(0, plen + 3));
        fbit = int'($urandom_range(0, 7));
      end
      if ($urandom_range(0, 2) == 0) extra = int'($urandom_range(1, 3));
      build(plen, fb, fbit);
      tot    = tx_q.size();
      efcs   = (extra == 0) && model_ok();
      elen   = (tot < 64) || (tot > 1522);
      ealign = (extra != 0);
      clear_mon();
      send_pre();
      send_body(extra);
      check_frame($sformatf("rand%0d", r), efcs, elen, ealign,
                  (tot > 2047) ? 2047 : tot);
    end

    chk("no_dv_done_overlap", overlap, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/eth_rx_fcs.md
Name: eth_rx_fcs

Overview:
- Receive-side counterpart of the transmit FCS generator, on the RMII receive path.
- Consumes the receive dibit stream, detects preamble/SFD, and de-serialises payload dibits into bytes.
- Runs a serial CRC-32 over every post-SFD dibit, including the received FCS. At end of frame it reports CRC, alignment and length status to the MAC receive logic.

Parameters:
- MIN_LEN, 64, minimum legal frame length in bytes (DA through FCS).
- MAX_LEN, 1522, maximum legal frame length in bytes.
- CNT_W, 11, byte counter width; saturates at 2^CNT_W-1.

Ports:
- clk  in  1  RMII reference clock, 50 MHz; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- rx_dv  in  1  receive data valid, already deglitched upstream.
- rxd  in  2  receive dibit; rxd[0] is the earlier bit on the wire.
- frame_start  out  1  one-cycle pulse, cycle after the SFD dibit is sampled.
- data_byte  out  8  assembled byte, LSB = first received bit.
- data_valid  out  1  one-cycle pulse qualifying data_byte.
- frame_done  out  1  one-cycle pulse, end of a frame that reached DATA.
- fcs_ok  out  1  CRC residue correct and byte-aligned; held until next frame_start.
- err_align  out  1  frame ended on a non-byte boundary; held.
- err_len  out  1  byte_count < MIN_LEN or > MAX_LEN; held.
- byte_count  out  CNT_W  bytes received including FCS; held.

Behaviour:
- Reset, asynchronous: state=IDLE, CRC register all ones, dibit phase=0.
  - All outputs 0, including status and byte_count.
  - A reset mid-frame aborts the frame; no frame_done follows.
- States: IDLE, PREAMBLE, DATA, DROP.
- IDLE:
  - rx_dv=1 → PREAMBLE; the dibit sampled in that cycle is evaluated by the PREAMBLE rules.
- PREAMBLE:
  - rxd=2'b00 or 2'b01 → stay.
  - rxd=2'b11 (SFD tail) → DATA. Load CRC all ones, phase=0, byte counter=0, clear status outputs, pulse frame_start next cycle.
  - rxd=2'b10 → DROP.
  - rx_dv=0 → IDLE with no frame_done.
- DATA:
  - Each cycle with rx_dv=1, shift the dibit into the byte shifter and advance phase 0..3.
  - On the phase-3 dibit, data_byte/data_valid are registered and appear the next cycle, one cycle after the 4th dibit is sampled. byte_count increments, saturating.
  - The CRC is updated every dibit, two bit steps per cycle: rxd[0] first, then rxd[1].
  - Bit step: fb = crc[31] ^ bit; crc = {crc[30:0],1'b0} ^ (fb ? 32'h04C11DB7 : 0).
  - rx_dv=0 → IDLE; frame_done pulses the next cycle, with:
    - fcs_ok = (crc == 32'hC704DD7B) && phase==0
    - err_align = phase!=0
    - err_len = count<MIN_LEN || count>MAX_LEN
  - A partial byte at the end is discarded; no data_valid for it.
- DROP:
  - Ignore input until rx_dv=0 → IDLE. No pulses.
- A frame is aborted only by reset. rx_dv low for one cycle ends the frame, and the next rx_dv high starts a new preamble search.
- Status outputs change only at frame_start (cleared) and frame_done (set).
- data_valid and frame_done are never asserted in the same cycle.

Decomposition:
- eth_pkg holds:
  - CRC32_POLY = 32'h04C11DB7
  - CRC32_INIT = 32'hFFFFFFFF
  - CRC32_RESIDUE = 32'hC704DD7B
  - PREAMBLE_DIBIT = 2'b01, SFD_DIBIT = 2'b11
  - rx state enum
- One sub-module, eth_crc32_dibit: a combinational two-bit CRC step (crc_in, dibit → crc_out), shared later with the TX side.

Test Plan:
- 7×0x55, 0xD5, 60 payload bytes, correct 4-byte FCS, all LSB-first dibits → frame_start once, 64 data_valid pulses, frame_done with fcs_ok=1, err_len=0, err_align=0, byte_count=64.
- Payload ASCII "123456789" followed by FCS bytes 0x26,0x39,0xF4,0xCB → fcs_ok=1, byte_count=13, err_len=1; data_byte sequence 0x31..0x39 then the FCS bytes.
- Same 64-byte frame with bit 0 of payload byte 10 flipped → fcs_ok=0, err_len=0, byte_count=64.
- Good 64-byte frame plus 1 extra dibit before rx_dv drops → err_align=1, fcs_ok=0, byte_count=64, no 65th data_valid.
- Preamble containing a 2'b10 dibit before the SFD → no frame_start, no data_valid, no frame_done; the next good frame is received normally.
- reset asserted after 20 payload bytes, released, then a good frame sent → outputs 0 immediately on reset, no frame_done for the aborted frame, the following frame gives fcs_ok=1.
